// File: rtl/inst_fetch_if.sv
// Exception encoding shared by the fetch engine and its neighbours, plus the
// bundle of icache request/response, predictor hint and ibuf push signals.
package inst_fetch_pkg;
    typedef logic [5:0] exception_t;
    localparam exception_t EXC_NONE = 6'h00;
    localparam exception_t EXC_PIF  = 6'h03;
    localparam exception_t EXC_ADEF = 6'h08;
endpackage

interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_inst1;
    logic [31:0] icache_resp_inst2;
    logic        icache_resp_exc;
    exception_t  icache_resp_exc_type;
    logic        bp_taken1;
    logic        bp_taken2;
    logic [31:0] bp_target1;
    logic [31:0] bp_target2;
    logic        ibuf_ready;
    logic [1:0]  out_size;
    logic [31:0] out_pc1;
    logic [31:0] out_pc2;
    logic [31:0] out_inst1;
    logic [31:0] out_inst2;
    logic        out_pred_taken1;
    logic        out_pred_taken2;
    logic [31:0] out_pred_target1;
    logic [31:0] out_pred_target2;
    logic        out_have_exception1;
    exception_t  out_exception_type1;

    // Fetch engine side
    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_req_ready, icache_resp_valid, icache_resp_inst1, icache_resp_inst2,
        input  icache_resp_exc, icache_resp_exc_type,
        input  bp_taken1, bp_taken2, bp_target1, bp_target2, ibuf_ready,
        output out_size, out_pc1, out_pc2, out_inst1, out_inst2,
        output out_pred_taken1, out_pred_taken2, out_pred_target1, out_pred_target2,
        output out_have_exception1, out_exception_type1
    );

    // icache / predictor / ibuf side
    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_req_ready, icache_resp_valid, icache_resp_inst1, icache_resp_inst2,
        output icache_resp_exc, icache_resp_exc_type,
        output bp_taken1, bp_taken2, bp_target1, bp_target2, ibuf_ready,
        input  out_size, out_pc1, out_pc2, out_inst1, out_inst2,
        input  out_pred_taken1, out_pred_taken2, out_pred_target1, out_pred_target2,
        input  out_have_exception1, out_exception_type1
    );
endinterface

// File: rtl/inst_fetch.sv
// Fetch engine: holds the fetch PC, keeps one icache request in flight and pushes
// 0/1/2 instructions per response into the instruction buffer.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [31:0]  flush_target,
    inst_fetch_if.master fe
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_CANCEL = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic        req_valid_s;
    logic [31:0] req_addr_s;
    logic        push_resp_s;
    logic        push_adef_s;
    logic [1:0]  resp_size_s;
    logic [31:0] resp_next_pc_s;

    // Response slot count and the PC that follows this response
    always_comb begin
        resp_size_s    = 2'd2;
        resp_next_pc_s = pc_q + 32'd8;
        if (pc_q[2] || fe.icache_resp_exc || fe.bp_taken1) begin
            resp_size_s = 2'd1;
        end else begin
            resp_size_s = 2'd2;
        end
        if (fe.icache_resp_exc) begin
            resp_next_pc_s = pc_q;
        end else if (fe.bp_taken1) begin
            resp_next_pc_s = fe.bp_target1;
        end else if (resp_size_s == 2'd2 && fe.bp_taken2) begin
            resp_next_pc_s = fe.bp_target2;
        end else if (resp_size_s == 2'd2) begin
            resp_next_pc_s = pc_q + 32'd8;
        end else begin
            resp_next_pc_s = pc_q + 32'd4;
        end
    end

    // Next-state, next-PC and request/push decisions; flush overrides everything
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_valid_s = 1'b0;
        req_addr_s  = pc_q;
        push_resp_s = 1'b0;
        push_adef_s = 1'b0;
        if (reset) begin
            state_d = ST_RUN;
            pc_d    = RESET_PC;
        end else if (flush) begin
            pc_d = flush_target;
            // A request still in flight must have its response swallowed
            if ((state_q == ST_WAIT || state_q == ST_CANCEL) && !fe.icache_resp_valid) begin
                state_d = ST_CANCEL;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pc_q[1:0] != 2'b00) begin
                        if (fe.ibuf_ready) begin
                            push_adef_s = 1'b1;
                            state_d     = ST_HOLD;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        req_valid_s = fe.ibuf_ready;
                        if (req_valid_s && fe.icache_req_ready) begin
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_WAIT: begin
                    if (fe.icache_resp_valid) begin
                        push_resp_s = 1'b1;
                        if (fe.icache_resp_exc) begin
                            state_d = ST_HOLD;
                            pc_d    = pc_q;
                        end else begin
                            pc_d = resp_next_pc_s;
                            // Misaligned targets fall back to RUN so the ADEF path reports them
                            req_valid_s = fe.ibuf_ready && (resp_next_pc_s[1:0] == 2'b00);
                            req_addr_s  = resp_next_pc_s;
                            if (req_valid_s && fe.icache_req_ready) begin
                                state_d = ST_WAIT;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_CANCEL: begin
                    if (fe.icache_resp_valid) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_CANCEL;
                    end
                end
                ST_HOLD: begin
                    state_d = ST_HOLD;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State and fetch PC registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign fe.icache_req_valid = req_valid_s;
    assign fe.icache_req_addr  = req_addr_s;

    // Push bus: driven from the response (or the ADEF tag) in the push cycle, zero otherwise
    always_comb begin
        fe.out_size            = 2'd0;
        fe.out_pc1             = 32'h0000_0000;
        fe.out_pc2             = 32'h0000_0000;
        fe.out_inst1           = 32'h0000_0000;
        fe.out_inst2           = 32'h0000_0000;
        fe.out_pred_taken1     = 1'b0;
        fe.out_pred_taken2     = 1'b0;
        fe.out_pred_target1    = 32'h0000_0000;
        fe.out_pred_target2    = 32'h0000_0000;
        fe.out_have_exception1 = 1'b0;
        fe.out_exception_type1 = EXC_NONE;
        if (push_adef_s) begin
            fe.out_size            = 2'd1;
            fe.out_pc1             = pc_q;
            fe.out_have_exception1 = 1'b1;
            fe.out_exception_type1 = EXC_ADEF;
        end else if (push_resp_s) begin
            fe.out_size            = resp_size_s;
            fe.out_pc1             = pc_q;
            fe.out_pc2             = pc_q + 32'd4;
            fe.out_inst1           = fe.icache_resp_inst1;
            fe.out_inst2           = fe.icache_resp_inst2;
            fe.out_pred_taken1     = fe.bp_taken1;
            fe.out_pred_taken2     = fe.bp_taken2;
            fe.out_pred_target1    = fe.bp_target1;
            fe.out_pred_target2    = fe.bp_target2;
            fe.out_have_exception1 = fe.icache_resp_exc;
            fe.out_exception_type1 = fe.icache_resp_exc ? fe.icache_resp_exc_type : EXC_NONE;
        end else begin
            fe.out_size = 2'd0;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: the bench plays icache, predictor and ibuf
// cycle by cycle and checks the request and push buses against hand-computed values.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] flush_target;
    int          total;
    int          bad;

    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(32'h1c00_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .flush_target (flush_target),
        .fe           (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input logic v, input logic [31:0] i1, input logic [31:0] i2,
                        input logic t1, input logic [31:0] g1,
                        input logic t2, input logic [31:0] g2);
        bus.icache_resp_valid    = v;
        bus.icache_resp_inst1    = i1;
        bus.icache_resp_inst2    = i2;
        bus.icache_resp_exc      = 1'b0;
        bus.icache_resp_exc_type = EXC_NONE;
        bus.bp_taken1            = t1;
        bus.bp_target1           = g1;
        bus.bp_taken2            = t2;
        bus.bp_target2           = g2;
    endtask

    task automatic idle();
        resp(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        flush = 1'b0;
        flush_target = 32'h0;
        bus.icache_req_ready = 1'b1;
        bus.ibuf_ready       = 1'b1;
        idle();
        #3;
        chk("rst_req_valid", {31'd0, bus.icache_req_valid}, 32'd0);
        chk("rst_size", {30'd0, bus.out_size}, 32'd0);
        tick();
        reset = 1'b0;

        // First request from RESET_PC, out data still zero
        #3;
        chk("req0_valid", {31'd0, bus.icache_req_valid}, 32'd1);
        chk("req0_addr", bus.icache_req_addr, 32'h1c00_0000);
        chk("pre_size", {30'd0, bus.out_size}, 32'd0);
        chk("pre_pc1", bus.out_pc1, 32'h0);
        tick();

        resp(1'b1, 32'h1111_0001, 32'h1111_0002, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        chk("r1_size", {30'd0, bus.out_size}, 32'd2);
        chk("r1_pc1", bus.out_pc1, 32'h1c00_0000);
        chk("r1_pc2", bus.out_pc2, 32'h1c00_0004);
        chk("r1_inst1", bus.out_inst1, 32'h1111_0001);
        chk("r1_inst2", bus.out_inst2, 32'h1111_0002);
        chk("r1_b2b_addr", bus.icache_req_addr, 32'h1c00_0008);
        chk("r1_b2b_valid", {31'd0, bus.icache_req_valid}, 32'd1);
        tick();

        resp(1'b1, 32'h1111_0003, 32'h1111_0004, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        chk("r2_size", {30'd0, bus.out_size}, 32'd2);
        chk("r2_pc1", bus.out_pc1, 32'h1c00_0008);
        chk("r2_pc2", bus.out_pc2, 32'h1c00_000c);
        chk("r2_b2b_addr", bus.icache_req_addr, 32'h1c00_0010);
        tick();

        // Flush coincident with the response: response dropped
        flush = 1'b1;
        flush_target = 32'h1c00_0014;
        resp(1'b1, 32'h2222_0001, 32'h2222_0002, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        chk("fl_resp_size", {30'd0, bus.out_size}, 32'd0);
        chk("fl_resp_req", {31'd0, bus.icache_req_valid}, 32'd0);
        tick();
        flush = 1'b0;
        idle();
        #3;
        chk("fl_req_valid", {31'd0, bus.icache_req_valid}, 32'd1);
        chk("fl_req_addr", bus.icache_req_addr, 32'h1c00_0014);
        tick();

        // pc[2]=1 gives a single slot
        resp(1'b1, 32'h3333_0001, 32'h3333_0002, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        chk("odd_size", {30'd0, bus.out_size}, 32'd1);
        chk("odd_pc1", bus.out_pc1, 32'h1c00_0014);
        chk("odd_inst1", bus.out_inst1, 32'h3333_0001);
        chk("odd_next", bus.icache_req_addr, 32'h1c00_0018);
        tick();

        resp(1'b1, 32'h3333_0003, 32'h3333_0004, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        chk("r18_size", {30'd0, bus.out_size}, 32'd2);
        chk("r18_next", bus.icache_req_addr, 32'h1c00_0020);
        tick();

        // Slot1 predicted taken
        resp(1'b1, 32'h4444_0001, 32'h4444_0002, 1'b1, 32'h1c00_0100, 1'b0, 32'h0);
        #3;
        chk("bp1_size", {30'd0, bus.out_size}, 32'd1);
        chk("bp1_pc1", bus.out_pc1, 32'h1c00_0020);
        chk("bp1_taken", {31'd0, bus.out_pred_taken1}, 32'd1);
        chk("bp1_target", bus.out_pred_target1, 32'h1c00_0100);
        chk("bp1_next", bus.icache_req_addr, 32'h1c00_0100);
        tick();

        // Slot2 predicted taken, ibuf full: push anyway, no new request
        bus.ibuf_ready = 1'b0;
        resp(1'b1, 32'h5555_0001, 32'h5555_0002, 1'b0, 32'h0, 1'b1, 32'h1c00_0300);
        #3;
        chk("bp2_size", {30'd0, bus.out_size}, 32'd2);
        chk("bp2_pc1", bus.out_pc1, 32'h1c00_0100);
        chk("bp2_taken2", {31'd0, bus.out_pred_taken2}, 32'd1);
        chk("bp2_target2", bus.out_pred_target2, 32'h1c00_0300);
        chk("bp2_noreq", {31'd0, bus.icache_req_valid}, 32'd0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("full_noreq", {31'd0, bus.icache_req_valid}, 32'd0);
            chk("full_size", {30'd0, bus.out_size}, 32'd0);
            tick();
        end

        // Request held while icache stalls
        bus.ibuf_ready = 1'b1;
        bus.icache_req_ready = 1'b0;
        #3;
        chk("stall_valid", {31'd0, bus.icache_req_valid}, 32'd1);
        chk("stall_addr", bus.icache_req_addr, 32'h1c00_0300);
        tick();
        bus.icache_req_ready = 1'b1;
        #3;
        chk("stall_addr2", bus.icache_req_addr, 32'h1c00_0300);
        tick();

        // Fetch exception on the response
        resp(1'b1, 32'h6666_0001, 32'h6666_0002, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.icache_resp_exc = 1'b1;
        bus.icache_resp_exc_type = EXC_PIF;
        #3;
        chk("pif_size", {30'd0, bus.out_size}, 32'd1);
        chk("pif_pc1", bus.out_pc1, 32'h1c00_0300);
        chk("pif_have", {31'd0, bus.out_have_exception1}, 32'd1);
        chk("pif_type", {26'd0, bus.out_exception_type1}, {26'd0, EXC_PIF});
        chk("pif_noreq", {31'd0, bus.icache_req_valid}, 32'd0);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            #3;
            chk("hold_noreq", {31'd0, bus.icache_req_valid}, 32'd0);
            chk("hold_size", {30'd0, bus.out_size}, 32'd0);
            tick();
        end

        // Misaligned flush target raises ADEF and freezes
        flush = 1'b1;
        flush_target = 32'h1c00_0002;
        #3;
        chk("fl2_noreq", {31'd0, bus.icache_req_valid}, 32'd0);
        tick();
        flush = 1'b0;
        #3;
        chk("adef_size", {30'd0, bus.out_size}, 32'd1);
        chk("adef_pc1", bus.out_pc1, 32'h1c00_0002);
        chk("adef_inst1", bus.out_inst1, 32'h0);
        chk("adef_have", {31'd0, bus.out_have_exception1}, 32'd1);
        chk("adef_type", {26'd0, bus.out_exception_type1}, {26'd0, EXC_ADEF});
        chk("adef_noreq", {31'd0, bus.icache_req_valid}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("adef_hold_req", {31'd0, bus.icache_req_valid}, 32'd0);
            chk("adef_hold_size", {30'd0, bus.out_size}, 32'd0);
            tick();
        end

        // Flush while waiting, another flush while cancelling, late response dropped
        flush = 1'b1;
        flush_target = 32'h1c00_0040;
        tick();
        flush = 1'b0;
        #3;
        chk("c_req_addr", bus.icache_req_addr, 32'h1c00_0040);
        tick();
        flush = 1'b1;
        flush_target = 32'h1c00_0080;
        #3;
        chk("c_fl_size", {30'd0, bus.out_size}, 32'd0);
        tick();
        flush_target = 32'h1c00_0090;
        #3;
        chk("c_fl2_req", {31'd0, bus.icache_req_valid}, 32'd0);
        tick();
        flush = 1'b0;
        #3;
        chk("c_wait_req", {31'd0, bus.icache_req_valid}, 32'd0);
        tick();
        resp(1'b1, 32'h7777_0001, 32'h7777_0002, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        chk("c_drop_size", {30'd0, bus.out_size}, 32'd0);
        chk("c_drop_req", {31'd0, bus.icache_req_valid}, 32'd0);
        tick();
        idle();
        bus.icache_req_ready = 1'b0;
        #3;
        chk("c_new_valid", {31'd0, bus.icache_req_valid}, 32'd1);
        chk("c_new_addr", bus.icache_req_addr, 32'h1c00_0090);
        tick();

        // PC wrap at the top of the address space
        bus.icache_req_ready = 1'b1;
        flush = 1'b1;
        flush_target = 32'hffff_fff8;
        tick();
        flush = 1'b0;
        #3;
        chk("w_req_addr", bus.icache_req_addr, 32'hffff_fff8);
        tick();
        resp(1'b1, 32'h8888_0001, 32'h8888_0002, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        chk("w_size", {30'd0, bus.out_size}, 32'd2);
        chk("w_pc2", bus.out_pc2, 32'hffff_fffc);
        chk("w_next", bus.icache_req_addr, 32'h0000_0000);
        tick();
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
